// File: rtl/cim_dot_sched.sv
`default_nettype none
// ============================================================================
// Module   : cim_dot_sched
// Purpose  : Two-requester job scheduler for a 2-wide BF16 dot-product
//            engine. One job is in flight at a time. Arbitration is
//            round-robin against the id of the last completed job. The
//            engine has a fixed ENG_LAT-cycle latency, so the scheduler
//            times the engine with a down-counter and does not need a
//            handshake back from it.
//
// Parameters
//   ENG_LAT      cycles from eng_start to eng_result valid (1..255)
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   reqN_valid   requester N presents a job (N = 0, 1)
//   reqN_ready   job from requester N accepted this cycle (combinational)
//   reqN_a/b     packed BF16 operands, [31:16] = elem 0, [15:0] = elem 1
//   eng_start    single-cycle engine start pulse
//   eng_a/b      engine operands, held from ISSUE through WAIT, 0 in IDLE
//   eng_result   BF16 engine result
//   rsp_valid    response available
//   rsp_ready    consumer accepts the response
//   rsp_data     BF16 result
//   rsp_id       requester that owns the response
//   busy         state is not IDLE
//   jobs_done    completed-response count (wraps)
//
// Revision : 1.0 - initial release
// ============================================================================
module cim_dot_sched #(
    parameter int ENG_LAT = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        eng_start,
    output logic [31:0] eng_a,
    output logic [31:0] eng_b,
    input  logic [15:0] eng_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic        rsp_id,
    output logic        busy,
    output logic [15:0] jobs_done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // WAIT covers ENG_LAT cycles: counts ENG_LAT-1 down to 0 inclusive.
    localparam logic [7:0] c_cnt_load = 8'(ENG_LAT - 1);

    state_t     r_state;
    logic [7:0] r_cnt;
    logic       r_rr_ptr;   // id of the last completed job
    logic       r_id;       // id of the job in flight

    logic       w_idle;
    logic       w_sel;      // granted requester when anything is valid
    logic       w_accept;

    // Ready is suppressed while reset is asserted, so no requester sees a
    // grant from the IDLE state that reset forces.
    assign w_idle     = rst_n && (r_state == ST_IDLE);

    // With both valid, the requester that did not complete last wins;
    // otherwise the only valid requester wins.
    assign w_sel      = (req0_valid && req1_valid) ? ~r_rr_ptr : req1_valid;

    assign req0_ready = w_idle && req0_valid && !w_sel;
    assign req1_ready = w_idle && req1_valid &&  w_sel;
    assign w_accept   = req0_ready || req1_ready;

    assign busy       = (r_state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_rr_ptr  <= 1'b1;
            r_id      <= 1'b0;
            eng_start <= 1'b0;
            eng_a     <= '0;
            eng_b     <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= 1'b0;
            jobs_done <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        // Operands are captured here, so later changes on
                        // the request bus cannot disturb the job in flight.
                        eng_a     <= w_sel ? req1_a : req0_a;
                        eng_b     <= w_sel ? req1_b : req0_b;
                        r_id      <= w_sel;
                        eng_start <= 1'b1;
                        r_state   <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    eng_start <= 1'b0;
                    r_cnt     <= c_cnt_load;
                    r_state   <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (r_cnt == 8'd0) begin
                        rsp_data  <= eng_result;
                        rsp_id    <= r_id;
                        rsp_valid <= 1'b1;
                        eng_a     <= '0;
                        eng_b     <= '0;
                        r_state   <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end

                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        jobs_done <= jobs_done + 16'd1;
                        r_rr_ptr  <= rsp_id;
                        r_state   <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/cim_dot_sched.md
CIM_DOT_SCHED -- requirements
Module: cim_dot_sched

Interface
REQ-001 The block SHALL have parameter ENG_LAT, default 10: the number of cycles from an eng_start pulse to eng_result being valid (legal range 1..255).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have ports req0_valid and req1_valid, input, 1 bit each: requester 0 or 1 presents a job.
REQ-005 The block SHALL have ports req0_ready and req1_ready, output, 1 bit each: the job from that requester is accepted this cycle.
REQ-006 The block SHALL have ports req0_a, req0_b, req1_a and req1_b, input, 32 bits each: two packed BF16 operands per vector; bits [31:16] hold element 0 and bits [15:0] hold element 1.
REQ-007 The block SHALL have port eng_start, output, 1 bit: single-cycle start pulse to the 2-wide BF16 dot-product engine.
REQ-008 The block SHALL have ports eng_a and eng_b, output, 32 bits each: the engine operands.
REQ-009 The block SHALL have port eng_result, input, 16 bits: the BF16 dot-product result from the engine.
REQ-010 The block SHALL have port rsp_valid, output, 1 bit: a response is available.
REQ-011 The block SHALL have port rsp_ready, input, 1 bit: the consumer accepts the response.
REQ-012 The block SHALL have port rsp_data, output, 16 bits: the BF16 result.
REQ-013 The block SHALL have port rsp_id, output, 1 bit: the index of the requester that owns the response.
REQ-014 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-015 The block SHALL have port jobs_done, output, 16 bits: count of completed responses.

Function
REQ-016 The FSM SHALL have the states IDLE, ISSUE, WAIT and RESP, and SHALL serve exactly one job at a time.
REQ-017 In IDLE, the grant SHALL follow these rules.
- Only one requester valid: grant that requester.
- Both valid: grant the requester that is not rr_ptr, where rr_ptr is the id of the last completed job (reset value 1, so requester 0 wins first).
REQ-018 reqN_ready SHALL be combinational and high only in IDLE, only for the granted requester; at most one ready SHALL be high in any cycle.
REQ-019 On acceptance (valid and ready both high), the block SHALL register a, b and id, and move to ISSUE.
REQ-020 In ISSUE, eng_start SHALL be 1 for exactly one cycle; the block SHALL then load cnt with ENG_LAT-1 and move to WAIT.
REQ-021 eng_a and eng_b SHALL hold the registered operands stable from ISSUE through the end of WAIT; they SHALL be 0 in IDLE.
REQ-022 WAIT SHALL last exactly ENG_LAT cycles.
- cnt decrements by 1 each cycle.
- In the cycle cnt==0: capture eng_result into rsp_data and move to RESP.
REQ-023 Latency SHALL be fixed relative to the acceptance cycle T.
- eng_start is high in cycle T+1.
- rsp_valid first goes high in cycle T+ENG_LAT+2.
REQ-024 In RESP, rsp_valid SHALL be 1 and rsp_data and rsp_id SHALL be stable until rsp_ready is sampled high.
- In that cycle: jobs_done increments (wrapping 0xFFFF to 0x0000), rr_ptr takes rsp_id, and the state returns to IDLE.
REQ-025 A new job SHALL NOT be accepted in the same cycle as the rsp handshake; the earliest next acceptance SHALL be the following cycle.
REQ-026 rsp_ready in any state other than RESP SHALL be ignored.
REQ-027 A requester that drops valid before being granted SHALL be treated as not requesting; no job SHALL be lost or duplicated.
REQ-028 Operand changes on reqN_a and reqN_b after acceptance SHALL have no effect on the job in flight.

Reset
REQ-029 Asserting rst_n=0 at any time, including mid-WAIT or mid-RESP, SHALL asynchronously apply the following.
- state=IDLE, cnt=0, rr_ptr=1.
- eng_start=0, eng_a=eng_b=0.
- rsp_valid=0, rsp_data=0, rsp_id=0.
- jobs_done=0, busy=0, both readies low.
REQ-030 Any in-flight job SHALL be discarded by reset without producing a response.
REQ-031 After rst_n deasserts, the first acceptance SHALL be possible on the next rising edge.

Verification
REQ-032 Single job: ENG_LAT=10; req0 with a=0x3F803F80 and b=0x40004000; the engine model returns 0x4080 -> eng_start high in T+1 only; rsp_valid in T+12; rsp_data=0x4080; rsp_id=0; jobs_done=1.
REQ-033 Contention: req0 and req1 both valid from reset -> order of service 0,1,0,1 over 4 jobs; one ready at a time; rsp_id follows 0,1,0,1.
REQ-034 Backpressure: rsp_ready held low for 20 cycles in RESP -> rsp_valid, rsp_data and rsp_id stay constant, busy=1, no new acceptance; release -> IDLE the next cycle.
REQ-035 Reset mid-WAIT (cycle T+5) -> all outputs go to reset values immediately; no response; jobs_done=0; the next job completes normally.
REQ-036 Counter wrap: preload 65535 completions (or force jobs_done=0xFFFF) and complete 1 more job -> jobs_done=0x0000.
REQ-037 ENG_LAT=1: single job -> eng_start in T+1; rsp_valid in T+3; eng_result sampled in cycle T+2.
